rfsm_control_unit: RTL and testbench

- Multicycle FSM controller for the 8-bit RISC_FSM core; sits directly upstream of the 8-bit ALU.
- Fetches 16-bit instructions over a req/ack handshake, decodes them, and drives the ALU's 3-bit alu_control, the register-file read/write addresses, and the write enable/select.
- ALU encoding driven: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT (a only).

---
 rtl/rfsm_control_unit.sv | 161 ++++++++++++++++
 tb/tb_rfsm_control_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfsm_control_unit.sv
// Multicycle fetch/decode/execute/writeback controller for the 8-bit RISC_FSM core.
// Latency: ALU op 4 cycles, LDI 3, NOP/JMP 2, plus 1 per fetch cycle spent waiting on imem_ack.
// Backpressure: FETCH holds imem_req high with a stable imem_addr until imem_ack; nothing advances without it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               leave IDLE/HALT and begin fetching (ignored while busy)
//   imem_addr/req/ack/data  instruction fetch handshake (data valid when ack=1)
//   rs1_addr, rs2_addr  register-file read addresses (ALU a / b)
//   alu_control         ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT
//   rf_we/waddr/wsel    register-file write strobe, address, source (0 ALU, 1 imm)
//   imm                 instruction bits [7:0]
//   busy, halted, illegal_op  status
module rfsm_control_unit #(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [2:0]      rs1_addr,
  output logic [2:0]      rs2_addr,
  output logic [2:0]      alu_control,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic            rf_wsel,
  output logic [7:0]      imm,
  output logic            busy,
  output logic            halted,
  output logic            illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;

  logic [3:0] op;
  logic [2:0] alu_sel;
  logic       in_ex_wb;

  assign op = ir_q[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RST_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          OP_NOP: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = PC_W'(ir_q[7:0]);
            state_d = S_FETCH;
          end
          OP_LDI:                                state_d = S_WRITEBACK;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: state_d = S_EXECUTE;
          OP_HALT:                               state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_EXECUTE: state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d      = RST_PC;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Opcode to ALU select; LDI (and anything else) leaves the ALU on ADD.
  always_comb begin
    alu_sel = 3'b000;
    case (op)
      OP_SUB:  alu_sel = 3'b001;
      OP_AND:  alu_sel = 3'b010;
      OP_OR:   alu_sel = 3'b011;
      OP_NOT:  alu_sel = 3'b100;
      default: alu_sel = 3'b000;
    endcase
  end

  // All outputs come from state_q/ir_q/pc_q only, so imem_data never reaches them combinationally.
  // Read addresses and ALU select stay valid across EXECUTE and WRITEBACK so the
  // ALU result is still present when the write strobe fires.
  assign in_ex_wb    = (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign rs1_addr    = in_ex_wb ? ir_q[8:6] : 3'd0;
  assign rs2_addr    = in_ex_wb ? ir_q[5:3] : 3'd0;
  assign alu_control = in_ex_wb ? alu_sel   : 3'b000;

  assign rf_we      = (state_q == S_WRITEBACK);
  assign rf_waddr   = rf_we ? ir_q[11:9] : 3'd0;
  assign rf_wsel    = rf_we && (op == OP_LDI);
  assign imm        = ir_q[7:0];
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_rfsm_control_unit.sv
module tb_rfsm_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [2:0]  rs1_addr, rs2_addr, alu_control, rf_waddr;
  logic        rf_we, rf_wsel;
  logic [7:0]  imm;
  logic        busy, halted, illegal_op;

  rfsm_control_unit #(.PC_W(8), .RST_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .alu_control(alu_control),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .imm(imm),
    .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] waddr;
    logic       wsel;
    logic [2:0] alu;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem [0:255];
  logic [7:0]  fetch_addr_q[$];
  int          fetch_cyc_q[$];
  int          run_q[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, ack_delay = 0, wait_cnt = 0, req_run = 0, addr_unstable = 0, wr_cnt = 0;
  logic [7:0]  run_addr;
  logic [2:0]  prev_alu, prev_rs1, prev_rs2;
  wr_t         mon_e, mon_got;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  // Expected register-file write for an instruction word.
  function automatic wr_t exp_of(input logic [15:0] ins);
    wr_t e;
    e.waddr = ins[11:9];
    e.wsel  = (ins[15:12] == 4'h6);
    e.rs1   = ins[8:6];
    e.rs2   = ins[5:3];
    e.imm   = ins[7:0];
    case (ins[15:12])
      4'h2:    e.alu = 3'b001;
      4'h3:    e.alu = 3'b010;
      4'h4:    e.alu = 3'b011;
      4'h5:    e.alu = 3'b100;
      default: e.alu = 3'b000;
    endcase
    return e;
  endfunction

  // Scoreboard: every write strobe pops one expected write; ALU ops also check
  // that the preceding (EXECUTE) cycle already showed the same ALU select/addresses.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_we === 1'b1) begin
        wr_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: rf_waddr=%0d rf_wsel=%0d, required no write", rf_waddr, rf_wsel);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_got = {rf_waddr, rf_wsel, alu_control, rs1_addr, rs2_addr, imm};
          if (mon_e.wsel) begin
            if ({mon_got.waddr, mon_got.wsel, mon_got.imm} !== {mon_e.waddr, mon_e.wsel, mon_e.imm})
              $display("FAIL ldi_write: got waddr=%0d wsel=%0d imm=%h, required waddr=%0d wsel=%0d imm=%h",
                       mon_got.waddr, mon_got.wsel, mon_got.imm, mon_e.waddr, mon_e.wsel, mon_e.imm);
            else n_pass++;
          end else begin
            if (mon_got !== mon_e)
              $display("FAIL alu_write: got %h, required %h (waddr,wsel,alu,rs1,rs2,imm)", mon_got, mon_e);
            else n_pass++;
            n_chk++;
            if ({prev_alu, prev_rs1, prev_rs2} !== {mon_e.alu, mon_e.rs1, mon_e.rs2})
              $display("FAIL execute_stage: got alu=%b rs1=%0d rs2=%0d, required alu=%b rs1=%0d rs2=%0d",
                       prev_alu, prev_rs1, prev_rs2, mon_e.alu, mon_e.rs1, mon_e.rs2);
            else n_pass++;
          end
        end
      end
      prev_alu = alu_control;
      prev_rs1 = rs1_addr;
      prev_rs2 = rs2_addr;
    end
  end

  // One clock; the memory model answers a pending fetch after ack_delay wait cycles.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (imem_req === 1'b1) begin
      if (req_run == 0) run_addr = imem_addr;
      else if (imem_addr !== run_addr) addr_unstable++;
      req_run++;
      if (wait_cnt == ack_delay) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        fetch_addr_q.push_back(imem_addr);
        fetch_cyc_q.push_back(cyc);
        run_q.push_back(req_run);
        wait_cnt  = 0;
        req_run   = 0;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 16'h8888;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
      req_run  = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    imem_ack = 1'b0;
    imem_data = 16'h0000;
    ack_delay = 0; wait_cnt = 0; req_run = 0; addr_unstable = 0; wr_cnt = 0;
    exp_q.delete(); fetch_addr_q.delete(); fetch_cyc_q.delete(); run_q.delete();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_halt(input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    n_chk++;
    if (halted !== 1'b1) $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", halted, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({imem_req, rf_we, busy, halted, illegal_op, rf_wsel} !== 6'b0)
      $display("FAIL reset_flags: got req,we,busy,halted,ill,wsel=%b, required 000000",
               {imem_req, rf_we, busy, halted, illegal_op, rf_wsel});
    else n_pass++;
    n_chk++;
    if ({imem_addr, imm} !== 16'h0000) $display("FAIL reset_addr_imm: got %h, required 0000", {imem_addr, imm});
    else n_pass++;
    n_chk++;
    if ({alu_control, rs1_addr, rs2_addr, rf_waddr} !== 12'h000)
      $display("FAIL reset_alu_regs: got %h, required 000", {alu_control, rs1_addr, rs2_addr, rf_waddr});
    else n_pass++;
    repeat (3) step();
    n_chk++;
    if (busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL idle_hold: busy=%b req=%b, required 0 0", busy, imem_req);
    else n_pass++;
  endtask

  task automatic test_ldi();
    do_reset();
    mem[0] = 16'h6A2F;
    exp_q.push_back(exp_of(16'h6A2F));
    kick();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL ldi_fetch: req=%b addr=%h, required 1 00", imem_req, imem_addr);
    else n_pass++;
    step();
    n_chk++;
    if (busy !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0)
      $display("FAIL ldi_decode: busy=%b req=%b we=%b, required 1 0 0", busy, imem_req, rf_we);
    else n_pass++;
    step();
    n_chk++;
    if ({rf_we, rf_waddr, rf_wsel, imm} !== {1'b1, 3'd5, 1'b1, 8'h2F})
      $display("FAIL ldi_wb: got we=%b waddr=%0d wsel=%b imm=%h, required 1 5 1 2f", rf_we, rf_waddr, rf_wsel, imm);
    else n_pass++;
    step();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01) $display("FAIL ldi_next_pc: req=%b addr=%h, required 1 01", imem_req, imem_addr);
    else n_pass++;
    run_until_halt(20);
    n_chk++;
    if (wr_cnt != 1 || exp_q.size() != 0) $display("FAIL ldi_writes: got %0d writes, %0d pending, required 1 0", wr_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_alu_ops();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem[i] = enc(4'(i + 1), 3'd1, 3'd2, 3'd3);
      exp_q.push_back(exp_of(mem[i]));
    end
    kick();
    run_until_halt(100);
    n_chk++;
    if (wr_cnt != 5 || exp_q.size() != 0) $display("FAIL alu_writes: got %0d writes, %0d pending, required 5 0", wr_cnt, exp_q.size());
    else n_pass++;
    n_chk++;
    if (fetch_cyc_q.size() != 6) $display("FAIL alu_fetches: got %0d fetches, required 6", fetch_cyc_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (fetch_cyc_q[i+1] - fetch_cyc_q[i] != 4)
          $display("FAIL alu_latency: instr %0d took %0d cycles, required 4", i, fetch_cyc_q[i+1] - fetch_cyc_q[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ack_wait();
    do_reset();
    ack_delay = 3;
    mem[0] = enc(4'h1, 3'd1, 3'd2, 3'd3);
    exp_q.push_back(exp_of(mem[0]));
    kick();
    run_until_halt(60);
    n_chk++;
    if (run_q.size() < 2 || run_q[0] != 4) $display("FAIL wait_req_len: got %0d req cycles, required 4", (run_q.size() > 0) ? run_q[0] : -1);
    else n_pass++;
    n_chk++;
    if (addr_unstable != 0) $display("FAIL wait_addr_stable: %0d address changes while waiting, required 0", addr_unstable);
    else n_pass++;
    n_chk++;
    if (fetch_cyc_q.size() < 2 || fetch_cyc_q[1] - fetch_cyc_q[0] != 7)
      $display("FAIL wait_latency: got %0d cycles, required 7", (fetch_cyc_q.size() > 1) ? fetch_cyc_q[1] - fetch_cyc_q[0] : -1);
    else n_pass++;
    n_chk++;
    if (wr_cnt != 1 || exp_q.size() != 0) $display("FAIL wait_writes: got %0d writes, required 1", wr_cnt);
    else n_pass++;
    ack_delay = 0;
  endtask

  task automatic test_jmp_wrap();
    logic [7:0] exp_a [4];
    int n = 0;
    exp_a = '{8'h00, 8'hFE, 8'hFF, 8'h00};
    do_reset();
    mem[0]     = 16'h70FE;
    mem[8'hFE] = 16'h0000;
    mem[8'hFF] = 16'h0000;
    kick();
    while (fetch_addr_q.size() < 4 && n < 50) begin
      step();
      n++;
    end
    n_chk++;
    if (fetch_addr_q.size() < 4) $display("FAIL jmp_timeout: got %0d fetches, required 4", fetch_addr_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (fetch_addr_q[i] !== exp_a[i]) $display("FAIL jmp_addr_seq: fetch %0d got %h, required %h", i, fetch_addr_q[i], exp_a[i]);
        else n_pass++;
      end
      n_chk++;
      if (fetch_cyc_q[1] - fetch_cyc_q[0] != 2) $display("FAIL jmp_latency: got %0d, required 2", fetch_cyc_q[1] - fetch_cyc_q[0]);
      else n_pass++;
    end
    n_chk++;
    if (wr_cnt != 0) $display("FAIL jmp_no_write: got %0d writes, required 0", wr_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    mem[0] = 16'h9000;
    kick();
    run_until_halt(20);
    n_chk++;
    if ({illegal_op, halted, busy} !== 3'b110)
      $display("FAIL illegal_halt: got ill,halted,busy=%b, required 110", {illegal_op, halted, busy});
    else n_pass++;
    mem[0] = 16'hF000;
    kick();
    n_chk++;
    if ({illegal_op, imem_req, busy, halted} !== 4'b0110 || imem_addr !== 8'h00)
      $display("FAIL illegal_restart: got ill,req,busy,halted=%b addr=%h, required 0110 00",
               {illegal_op, imem_req, busy, halted}, imem_addr);
    else n_pass++;
    run_until_halt(20);
    n_chk++;
    if (illegal_op !== 1'b0 || wr_cnt != 0) $display("FAIL illegal_clean: ill=%b writes=%0d, required 0 0", illegal_op, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[0] = enc(4'h2, 3'd1, 3'd2, 3'd3);
    kick();
    step();
    step();
    n_chk++;
    if (alu_control !== 3'b001 || rs1_addr !== 3'd2) $display("FAIL mid_execute: alu=%b rs1=%0d, required 001 2", alu_control, rs1_addr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, rf_we, imem_req, alu_control, rs1_addr, rs2_addr, imem_addr} !== 20'h0)
      $display("FAIL mid_reset_outputs: busy=%b we=%b req=%b alu=%b rs1=%0d rs2=%0d addr=%h, required all 0",
               busy, rf_we, imem_req, alu_control, rs1_addr, rs2_addr, imem_addr);
    else n_pass++;
    step();
    rst_n = 1'b1;
    mem[0] = 16'hF000;
    repeat (3) step();
    n_chk++;
    if (busy !== 1'b0 || imem_req !== 1'b0 || wr_cnt != 0)
      $display("FAIL mid_no_resume: busy=%b req=%b writes=%0d, required 0 0 0", busy, imem_req, wr_cnt);
    else n_pass++;
    kick();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL mid_restart: req=%b addr=%h, required 1 00", imem_req, imem_addr);
    else n_pass++;
    run_until_halt(20);
    n_chk++;
    if (wr_cnt != 0) $display("FAIL mid_no_write: got %0d writes, required 0", wr_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu_ops();
    test_ack_wait();
    test_jmp_wrap();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
